// File: rtl/sram_bus_arbiter.sv
// Shares one single-port asynchronous 16-bit SRAM between instruction fetch
// (IF) and load/store (MEM). Only one access runs at a time. An access is
// started only from IDLE, and MEM has priority over IF. The SRAM strobes,
// the address/data latches and the result pulses are all registered. The
// stall outputs are combinational so the hazard unit can freeze the
// pipeline in the same cycle a request appears.
module sram_bus_arbiter #(
  parameter int ADDR_W  = 18,  // SRAM address width; request address is zero-extended
  parameter int RD_WAIT = 1,   // cycles with oe_n low before read data is sampled (>=1)
  parameter int WR_WAIT = 1    // cycles with we_n held low (>=1)
) (
  input  logic              clk,
  input  logic              rst,        // synchronous, active-low
  // Instruction fetch port
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [15:0]       if_rdata,
  output logic              if_valid,
  // Load/store port
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_done,
  // Pipeline control
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy,
  // SRAM side
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  input  logic [15:0]       sram_din,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  // The wait counter must count up to the longer of the two wait phases.
  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Which port owns the access in flight (1 = MEM, 0 = IF).
  logic             serve_mem;

  // Decisions made in IDLE and at the end of an access.
  logic             want_mem;
  logic             want_if;
  logic             accept_mem;
  logic             accept_if;
  logic             rd_finish;
  logic             wr_finish;

  // Next values of the registered SRAM strobes.
  logic             ce_n_next;
  logic             oe_n_next;
  logic             we_n_next;
  logic             dq_oe_next;

  // A port whose completion pulse is high this cycle consumes its result
  // on this edge, so it is not re-accepted at the same edge.
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = (mem_read | mem_write) & ~mem_done;

  // Next-state logic: pick a requester in IDLE, time the read/write phases.
  always_comb begin
    // NOTE: every signal gets a default first so that no path through the
    // case statement leaves one unassigned (which would infer a latch).
    state_next = state;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    rd_finish  = 1'b0;
    wr_finish  = 1'b0;
    want_mem   = (mem_read | mem_write) & ~mem_done;
    want_if    = if_req & ~if_valid;

    case (state)
      IDLE: begin
        if (want_mem) begin
          accept_mem = 1'b1;
          // A simultaneous read+write request is treated as a write.
          state_next = mem_write ? WR_SETUP : RD;
        end else if (want_if) begin
          accept_if  = 1'b1;
          state_next = RD;
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          rd_finish  = 1'b1;
          state_next = IDLE;
        end
      end
      WR_SETUP: begin
        state_next = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt == WR_LAST) begin
          state_next = WR_HOLD;
        end
      end
      WR_HOLD: begin
        wr_finish  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The counter restarts from zero on every state entry and rests at zero in IDLE.
    if ((state_next != state) || (state_next == IDLE)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end

    // Strobes follow the state being entered, so they are glitch-free registers.
    ce_n_next  = (state_next == IDLE);
    oe_n_next  = (state_next != RD);
    we_n_next  = (state_next != WR_PULSE);
    dq_oe_next = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                 (state_next == WR_HOLD);
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from values sampled before the edge, independent of block order.
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Latch owner, address and write data at acceptance; they stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      serve_mem <= 1'b0;
      sram_addr <= '0;
      sram_dout <= '0;
    end else if (accept_mem) begin
      serve_mem <= 1'b1;
      sram_addr <= ADDR_W'(mem_addr);
      if (mem_write) begin
        sram_dout <= mem_wdata;
      end
    end else if (accept_if) begin
      serve_mem <= 1'b0;
      sram_addr <= ADDR_W'(if_addr);
    end
  end

  // Registered SRAM strobes; reset deasserts them at once, aborting any access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sram_ce_n  <= ce_n_next;
      sram_oe_n  <= oe_n_next;
      sram_we_n  <= we_n_next;
      sram_dq_oe <= dq_oe_next;
      busy       <= (state_next != IDLE);
    end
  end

  // Capture read data and issue one-cycle completion pulses; rdata holds between accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_valid  <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_valid <= rd_finish & ~serve_mem;
      mem_done <= (rd_finish & serve_mem) | wr_finish;
      if (rd_finish) begin
        if (serve_mem) begin
          mem_rdata <= sram_din;
        end else begin
          if_rdata <= sram_din;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter. Instance A uses the default timing and is
// compared every cycle against a transaction-timeline model. Instance B
// uses RD_WAIT=3 / WR_WAIT=2 and covers longer reads and reset during a
// write pulse. Each instance has its own behavioural asynchronous SRAM.
module tb_sram_bus_arbiter;

  localparam int RDW_A = 1;
  localparam int WRW_A = 1;
  localparam int RDW_B = 3;
  localparam int WRW_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A signals ----------------
  logic        rst_a = 1'b0;
  logic        if_req_a = 1'b0;
  logic [15:0] if_addr_a = '0;
  logic [15:0] if_rdata_a;
  logic        if_valid_a;
  logic        mem_read_a = 1'b0;
  logic        mem_write_a = 1'b0;
  logic [15:0] mem_addr_a = '0;
  logic [15:0] mem_wdata_a = '0;
  logic [15:0] mem_rdata_a;
  logic        mem_done_a;
  logic        stall_if_a;
  logic        stall_mem_a;
  logic        busy_a;
  logic [17:0] sram_addr_a;
  logic [15:0] sram_dout_a;
  logic [15:0] sram_din_a = 16'hDEAD;
  logic        dq_oe_a;
  logic        ce_n_a;
  logic        oe_n_a;
  logic        we_n_a;

  // ---------------- instance B signals ----------------
  logic        rst_b = 1'b0;
  logic        if_req_b = 1'b0;
  logic [15:0] if_addr_b = '0;
  logic [15:0] if_rdata_b;
  logic        if_valid_b;
  logic        mem_read_b = 1'b0;
  logic        mem_write_b = 1'b0;
  logic [15:0] mem_addr_b = '0;
  logic [15:0] mem_wdata_b = '0;
  logic [15:0] mem_rdata_b;
  logic        mem_done_b;
  logic        stall_if_b;
  logic        stall_mem_b;
  logic        busy_b;
  logic [17:0] sram_addr_b;
  logic [15:0] sram_dout_b;
  logic [15:0] sram_din_b = 16'hDEAD;
  logic        dq_oe_b;
  logic        ce_n_b;
  logic        oe_n_b;
  logic        we_n_b;

  sram_bus_arbiter #(.ADDR_W(18), .RD_WAIT(RDW_A), .WR_WAIT(WRW_A)) dut_a (
    .clk(clk), .rst(rst_a),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_rdata(if_rdata_a), .if_valid(if_valid_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .mem_done(mem_done_a),
    .stall_if(stall_if_a), .stall_mem(stall_mem_a), .busy(busy_a),
    .sram_addr(sram_addr_a), .sram_dout(sram_dout_a), .sram_din(sram_din_a),
    .sram_dq_oe(dq_oe_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a)
  );

  sram_bus_arbiter #(.ADDR_W(18), .RD_WAIT(RDW_B), .WR_WAIT(WRW_B)) dut_b (
    .clk(clk), .rst(rst_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_valid(if_valid_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_done(mem_done_b),
    .stall_if(stall_if_b), .stall_mem(stall_mem_b), .busy(busy_b),
    .sram_addr(sram_addr_b), .sram_dout(sram_dout_b), .sram_din(sram_din_b),
    .sram_dq_oe(dq_oe_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM models ----------------
  // A write completes when we_n rises while the chip is still selected.
  logic [15:0] mem_a [logic [17:0]];
  logic [15:0] mem_b [logic [17:0]];
  logic        prev_we_a = 1'b1;
  logic        prev_we_b = 1'b1;
  logic        saw_oe_a = 1'b0;
  logic        saw_done_b = 1'b0;

  function automatic logic [15:0] peek_a(input logic [17:0] a);
    return mem_a.exists(a) ? mem_a[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] peek_b(input logic [17:0] a);
    return mem_b.exists(a) ? mem_b[a] : 16'h0000;
  endfunction

  initial forever begin
    @(negedge clk);
    sram_din_a = (!ce_n_a && !oe_n_a) ? peek_a(sram_addr_a) : 16'hDEAD;
    if (!prev_we_a && we_n_a && !ce_n_a) mem_a[sram_addr_a] = sram_dout_a;
    prev_we_a = we_n_a;
    if (!oe_n_a) saw_oe_a = 1'b1;

    sram_din_b = (!ce_n_b && !oe_n_b) ? peek_b(sram_addr_b) : 16'hDEAD;
    if (!prev_we_b && we_n_b && !ce_n_b) mem_b[sram_addr_b] = sram_dout_b;
    prev_we_b = we_n_b;
    if (mem_done_b) saw_done_b = 1'b1;
  end

  // ---------------- transaction-timeline model of instance A ----------------
  // m_age counts cycles since acceptance (1 = first cycle of the access).
  // A read lasts RDW_A cycles, a write 1 + WRW_A + 1 cycles, then the pulse.
  bit          m_active = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_mem = 1'b0;
  int          m_age = 0;
  int          m_len = 0;
  logic [17:0] m_addr = '0;
  logic [15:0] m_dout = '0;
  logic [15:0] m_if_rdata = '0;
  logic [15:0] m_mem_rdata = '0;
  bit          m_if_valid = 1'b0;
  bit          m_mem_done = 1'b0;
  bit          go_mem;
  bit          go_if;

  initial forever begin
    @(posedge clk);
    if (!rst_a) begin
      m_active = 0; m_wr = 0; m_mem = 0; m_age = 0; m_len = 0;
      m_addr = '0; m_dout = '0; m_if_rdata = '0; m_mem_rdata = '0;
      m_if_valid = 0; m_mem_done = 0;
    end else begin
      go_mem = (mem_read_a || mem_write_a) && !m_mem_done;
      go_if  = if_req_a && !m_if_valid;
      m_if_valid = 0;
      m_mem_done = 0;
      if (m_active) begin
        m_age++;
        if (m_age == m_len) begin
          m_active = 0;
          if (!m_wr) begin
            if (m_mem) m_mem_rdata = peek_a(m_addr);
            else       m_if_rdata  = peek_a(m_addr);
          end
          if (m_mem) m_mem_done = 1;
          else       m_if_valid = 1;
        end
      end else if (go_mem || go_if) begin
        m_active = 1;
        m_age    = 1;
        m_mem    = go_mem;
        m_wr     = go_mem && mem_write_a;
        m_addr   = {2'b00, (go_mem ? mem_addr_a : if_addr_a)};
        m_len    = m_wr ? (WRW_A + 3) : (RDW_A + 1);
        if (m_wr) m_dout = mem_wdata_a;
      end
    end
  end

  // Compare instance A against the model on every falling edge.
  bit cmp_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("a_if_valid",  32'(if_valid_a),  32'(m_if_valid));
      check("a_if_rdata",  32'(if_rdata_a),  32'(m_if_rdata));
      check("a_mem_done",  32'(mem_done_a),  32'(m_mem_done));
      check("a_mem_rdata", 32'(mem_rdata_a), 32'(m_mem_rdata));
      check("a_busy",      32'(busy_a),      32'(m_active));
      check("a_ce_n",      32'(ce_n_a),      32'(!m_active));
      check("a_oe_n",      32'(oe_n_a),      32'(!(m_active && !m_wr)));
      check("a_we_n",      32'(we_n_a),
            32'(!(m_active && m_wr && m_age >= 2 && m_age <= WRW_A + 1)));
      check("a_dq_oe",     32'(dq_oe_a),     32'(m_active && m_wr));
      check("a_sram_addr", 32'(sram_addr_a), 32'(m_addr));
      check("a_sram_dout", 32'(sram_dout_a), 32'(m_dout));
      check("a_stall_if",  32'(stall_if_a),  32'(if_req_a && !m_if_valid));
      check("a_stall_mem", 32'(stall_mem_a), 32'((mem_read_a || mem_write_a) && !m_mem_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    mem_a[18'h00000] = 16'h1111;
    mem_a[18'h00010] = 16'h4A21;
    mem_a[18'h00011] = 16'h5B32;
    mem_a[18'h00020] = 16'h0C0D;
    mem_a[18'h08000] = 16'hBEEF;
    mem_b[18'h00005] = 16'h3C3C;

    // Reset held for two edges with a fetch pending.
    if_req_a = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_ce_n",     32'(ce_n_a), 1);
    check("rst_oe_n",     32'(oe_n_a), 1);
    check("rst_we_n",     32'(we_n_a), 1);
    check("rst_dq_oe",    32'(dq_oe_a), 0);
    check("rst_if_valid", 32'(if_valid_a), 0);
    check("rst_mem_done", 32'(mem_done_a), 0);
    check("rst_busy",     32'(busy_a), 0);
    check("rst_if_rdata", 32'(if_rdata_a), 0);
    check("rst_mem_rdata",32'(mem_rdata_a), 0);
    check("rst_sram_addr",32'(sram_addr_a), 0);
    check("rst_b_we_n",   32'(we_n_b), 1);
    check("rst_b_busy",   32'(busy_b), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy_a), 1);
    check("post_rst_oe_n", 32'(oe_n_a), 0);
    tick();
    check("post_rst_valid", 32'(if_valid_a), 1);
    check("post_rst_data",  32'(if_rdata_a), 'h1111);
    if_req_a = 1'b0;
    tick(); tick();

    // Fetch only, then back-to-back fetch with the address moved.
    if_req_a = 1'b1; if_addr_a = 16'h0010;
    #1 check("fetch_stall_c0", 32'(stall_if_a), 1);
    tick();
    check("fetch_oe_c1",    32'(oe_n_a), 0);
    check("fetch_stall_c1", 32'(stall_if_a), 1);
    tick();
    check("fetch_valid_c2", 32'(if_valid_a), 1);
    check("fetch_data_c2",  32'(if_rdata_a), 'h4A21);
    check("fetch_stall_c2", 32'(stall_if_a), 0);
    if_addr_a = 16'h0011;
    tick();
    check("fetch2_busy_c3",  32'(busy_a), 0);
    check("fetch2_valid_c3", 32'(if_valid_a), 0);
    tick();
    check("fetch2_busy_c4", 32'(busy_a), 1);
    check("fetch2_addr_c4", 32'(sram_addr_a), 'h00011);
    tick();
    check("fetch2_valid_c5", 32'(if_valid_a), 1);
    check("fetch2_data_c5",  32'(if_rdata_a), 'h5B32);
    if_req_a = 1'b0;
    tick(); tick();

    // Simultaneous fetch and load: the load goes first.
    if_req_a = 1'b1; if_addr_a = 16'h0020;
    mem_read_a = 1'b1; mem_addr_a = 16'h8000;
    #1 check("sim_stall_if_c0", 32'(stall_if_a), 1);
    check("sim_stall_mem_c0", 32'(stall_mem_a), 1);
    tick();
    check("sim_addr_c1", 32'(sram_addr_a), 'h08000);
    check("sim_oe_c1",   32'(oe_n_a), 0);
    tick();
    check("sim_done_c2",  32'(mem_done_a), 1);
    check("sim_rdata_c2", 32'(mem_rdata_a), 'hBEEF);
    check("sim_ifv_c2",   32'(if_valid_a), 0);
    check("sim_stall_c2", 32'(stall_if_a), 1);
    mem_read_a = 1'b0;
    tick();
    check("sim_busy_c3",  32'(busy_a), 1);
    check("sim_addr_c3",  32'(sram_addr_a), 'h00020);
    check("sim_stall_c3", 32'(stall_if_a), 1);
    tick();
    check("sim_ifv_c4",  32'(if_valid_a), 1);
    check("sim_ifd_c4",  32'(if_rdata_a), 'h0C0D);
    if_req_a = 1'b0;
    #1 check("sim_stall_c4", 32'(stall_if_a), 0);
    tick(); tick();

    // Store 0x1234 to 0x0100; inputs changed mid-access must be ignored.
    mem_write_a = 1'b1; mem_addr_a = 16'h0100; mem_wdata_a = 16'h1234;
    tick();
    check("st_dq_c1",   32'(dq_oe_a), 1);
    check("st_we_c1",   32'(we_n_a), 1);
    check("st_oe_c1",   32'(oe_n_a), 1);
    check("st_dout_c1", 32'(sram_dout_a), 'h1234);
    mem_addr_a = 16'h0200; mem_wdata_a = 16'hFFFF;
    tick();
    check("st_we_c2",   32'(we_n_a), 0);
    check("st_addr_c2", 32'(sram_addr_a), 'h00100);
    check("st_dout_c2", 32'(sram_dout_a), 'h1234);
    tick();
    check("st_we_c3", 32'(we_n_a), 1);
    check("st_dq_c3", 32'(dq_oe_a), 1);
    tick();
    check("st_done_c4", 32'(mem_done_a), 1);
    check("st_dq_c4",   32'(dq_oe_a), 0);
    check("st_ce_c4",   32'(ce_n_a), 1);
    check("st_mem_c4",  32'(peek_a(18'h00100)), 'h1234);
    mem_write_a = 1'b0;
    tick();
    mem_read_a = 1'b1; mem_addr_a = 16'h0100;
    for (int i = 0; i < 8 && mem_done_a !== 1'b1; i++) tick();
    check("rdback_done", 32'(mem_done_a), 1);
    check("rdback_data", 32'(mem_rdata_a), 'h1234);
    mem_read_a = 1'b0;
    tick(); tick();

    // Read and write together: treated as a write, no read strobe.
    saw_oe_a = 1'b0;
    mem_read_a = 1'b1; mem_write_a = 1'b1; mem_addr_a = 16'h0300; mem_wdata_a = 16'hA5A5;
    tick();
    check("rw_dq_c1", 32'(dq_oe_a), 1);
    check("rw_oe_c1", 32'(oe_n_a), 1);
    for (int i = 0; i < 8 && mem_done_a !== 1'b1; i++) tick();
    check("rw_done", 32'(mem_done_a), 1);
    mem_read_a = 1'b0; mem_write_a = 1'b0;
    check("rw_no_oe", 32'(saw_oe_a), 0);
    check("rw_mem",   32'(peek_a(18'h00300)), 'hA5A5);
    tick(); tick();

    // Instance B: read with RD_WAIT=3, done in cycle 4.
    mem_read_b = 1'b1; mem_addr_b = 16'h0005;
    tick();
    check("b_rd_oe_c1", 32'(oe_n_b), 0);
    tick();
    tick();
    check("b_rd_oe_c3",   32'(oe_n_b), 0);
    check("b_rd_done_c3", 32'(mem_done_b), 0);
    tick();
    check("b_rd_done_c4", 32'(mem_done_b), 1);
    check("b_rd_data_c4", 32'(mem_rdata_b), 'h3C3C);
    check("b_rd_oe_c4",   32'(oe_n_b), 1);
    mem_read_b = 1'b0;
    tick(); tick();

    // Instance B: reset asserted during WR_PULSE aborts the store.
    saw_done_b = 1'b0;
    mem_write_b = 1'b1; mem_addr_b = 16'h0040; mem_wdata_b = 16'h7777;
    tick();
    check("b_wr_dq_c1", 32'(dq_oe_b), 1);
    check("b_wr_we_c1", 32'(we_n_b), 1);
    tick();
    check("b_wr_we_c2", 32'(we_n_b), 0);
    rst_b = 1'b0;
    tick();
    check("b_abort_we",   32'(we_n_b), 1);
    check("b_abort_dq",   32'(dq_oe_b), 0);
    check("b_abort_ce",   32'(ce_n_b), 1);
    check("b_abort_busy", 32'(busy_b), 0);
    check("b_abort_done", 32'(mem_done_b), 0);
    rst_b = 1'b1;
    mem_write_b = 1'b0;
    tick(); tick(); tick(); tick();
    check("b_abort_no_done",  32'(saw_done_b), 0);
    check("b_abort_no_write", 32'(mem_b.exists(18'h00040)), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
